// File: rtl/pulse_ctrl_pkg.sv
// Shared types and helpers for the pulse measurement-window controller.
package pulse_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int MAX_W = 32;

  // Increment v by inc, holding at 2^w-1; callers truncate back to w bits.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                               input logic inc,
                                               input int unsigned w);
    logic [MAX_W-1:0] lim;
    lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    sat_inc = (inc && v != lim) ? v + MAX_W'(1) : v;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate-length down-counter: load arms a full window, en counts it down, done marks the last cycle.
module gate_timer #(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int TW = $clog2(WINDOW_CYCLES);

  logic [TW-1:0] value;

  always_ff @(posedge clk) begin
    if (!rst_n)                value <= '0;
    else if (load)             value <= TW'(WINDOW_CYCLES - 1);
    else if (en && value != '0) value <= value - TW'(1);
  end

  assign done = (value == '0);

endmodule

// File: rtl/pulse_window_ctrl.sv
// Measurement-window controller: clear, gate a fixed number of cycles while counting
// events with saturation, then hold the latched total under a valid/ack handshake.
module pulse_window_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 8,
  parameter bit AUTO_RESTART  = 1'b0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pulse_ev,
  input  logic             Result_ack,
  output logic [CNT_W-1:0] Result,
  output logic             Result_valid,
  output logic             Overflow,
  output logic             Gate_active,
  output logic             Busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_inc;
  logic             ovf, hit, tmr_done;

  gate_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk   (CLK),
    .rst_n (Reset),
    .load  (state == CLEAR),
    .en    (state == GATE),
    .done  (tmr_done)
  );

  assign count_inc = CNT_W'(sat_inc(MAX_W'(count), Pulse_ev, CNT_W));
  assign hit       = Pulse_ev && (count == '1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (Start && !Stop) state_nxt = CLEAR;
      CLEAR: state_nxt = GATE;
      GATE: begin
        if (Stop)          state_nxt = IDLE;
        else if (tmr_done) state_nxt = HOLD;
      end
      HOLD:  if (Result_ack) state_nxt = (AUTO_RESTART && !Stop) ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate_active/Busy are registered from the next state so they line up with state.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= IDLE;
      count        <= '0;
      ovf          <= 1'b0;
      Result       <= '0;
      Result_valid <= 1'b0;
      Overflow     <= 1'b0;
      Gate_active  <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state       <= state_nxt;
      Gate_active <= (state_nxt == GATE);
      Busy        <= (state_nxt != IDLE);
      unique case (state)
        CLEAR: begin
          count <= '0;
          ovf   <= 1'b0;
        end
        GATE: begin
          count <= count_inc;
          ovf   <= ovf | hit;
          // Final gate cycle: the pulse arriving now is folded into the latched total.
          if (tmr_done && !Stop) begin
            Result       <= count_inc;
            Overflow     <= ovf | hit;
            Result_valid <= 1'b1;
          end
        end
        HOLD: if (Result_ack) Result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Randomized bench for pulse_window_ctrl; expected totals come from popcount of in-gate pulses.
module tb_pulse_window_ctrl;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK = 1'b0, Reset = 1'b0;
  logic Start = 1'b0, Stop = 1'b0, Pulse_ev = 1'b0, Result_ack = 1'b0;
  logic [CW-1:0] Result;
  logic Result_valid, Overflow, Gate_active, Busy;

  logic start_a = 1'b0, stop_a = 1'b0, ev_a = 1'b0, ack_a = 1'b0;
  logic [CW-1:0] res_a;
  logic vld_a, ovf_a, gate_a, busy_a;

  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  pulse_window_ctrl #(.WINDOW_CYCLES(W), .CNT_W(CW), .AUTO_RESTART(1'b0)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Pulse_ev(Pulse_ev),
    .Result_ack(Result_ack), .Result(Result), .Result_valid(Result_valid),
    .Overflow(Overflow), .Gate_active(Gate_active), .Busy(Busy));

  pulse_window_ctrl #(.WINDOW_CYCLES(W), .CNT_W(CW), .AUTO_RESTART(1'b1)) dut_ar (
    .CLK(CLK), .Reset(Reset), .Start(start_a), .Stop(stop_a), .Pulse_ev(ev_a),
    .Result_ack(ack_a), .Result(res_a), .Result_valid(vld_a),
    .Overflow(ovf_a), .Gate_active(gate_a), .Busy(busy_a));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_count(input logic [W-1:0] gp);
    int n = $countones(gp);
    return (n > MAXC) ? MAXC : n;
  endfunction

  function automatic logic exp_ovf(input logic [W-1:0] gp);
    return $countones(gp) > MAXC;
  endfunction

  // Start at edge 0, CLEAR at edge 1, gp[i] sampled at edge 2+i; returns after edge 17.
  task automatic run_window(input logic [W-1:0] gp, input bit noise,
                            output int gcnt, output bit seq_ok);
    seq_ok = 1'b1;
    gcnt   = 0;
    Start = 1'b1; Pulse_ev = noise; tick;
    seq_ok = seq_ok & Busy & !Gate_active;
    Start = 1'b0; Pulse_ev = noise; tick;
    for (int i = 0; i < W; i++) begin
      if (Gate_active) gcnt++;
      if (Result_valid) seq_ok = 1'b0;
      Pulse_ev = gp[i];
      tick;
    end
    Pulse_ev = 1'b0;
    if (Gate_active || !Busy) seq_ok = 1'b0;
  endtask

  task automatic do_ack(input int hold_cycles, input bit noise);
    repeat (hold_cycles) begin Pulse_ev = noise; tick; end
    Pulse_ev = 1'b0; Result_ack = 1'b1; tick; Result_ack = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b1; Pulse_ev = 1'b1; start_a = 1'b1;
    tick; tick;
    Start = 1'b0; Pulse_ev = 1'b0; start_a = 1'b0;
    checks++; if ({Result, Result_valid, Overflow, Gate_active, Busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {Result, Result_valid, Overflow, Gate_active, Busy}); end
    checks++; if ({res_a, vld_a, ovf_a, gate_a, busy_a} !== '0) begin
      errors++; $display("FAIL reset_outputs_ar: got %h expected 0", {res_a, vld_a, ovf_a, gate_a, busy_a}); end
    Reset = 1'b1; tick;
  endtask

  task automatic test_basic;
    logic [W-1:0] gp = '0;
    int gcnt; bit ok;
    while ($countones(gp) < 5) gp[$urandom_range(W-1, 0)] = 1'b1;
    run_window(gp, 1'b0, gcnt, ok);
    checks++; if (gcnt != W) begin errors++; $display("FAIL basic_gate_len: got %0d expected %0d", gcnt, W); end
    checks++; if (!ok) begin errors++; $display("FAIL basic_sequence: got 0 expected 1"); end
    checks++; if (Result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", Result_valid); end
    checks++; if (Result !== 4'd5 || Overflow !== 1'b0) begin
      errors++; $display("FAIL basic_result: got %0d/%b expected 5/0", Result, Overflow); end
    do_ack(2, 1'b0);
    checks++; if (Result_valid !== 1'b0 || Busy !== 1'b0 || Result !== 4'd5) begin
      errors++; $display("FAIL basic_ack: got v=%b busy=%b r=%0d expected v=0 busy=0 r=5", Result_valid, Busy, Result); end
  endtask

  task automatic test_saturation;
    int gcnt; bit ok;
    run_window('1, 1'b0, gcnt, ok);
    checks++; if (Result !== 4'd15 || Overflow !== 1'b1 || Result_valid !== 1'b1) begin
      errors++; $display("FAIL sat_result: got %0d/%b/%b expected 15/1/1", Result, Overflow, Result_valid); end
    do_ack(1, 1'b0);
  endtask

  task automatic test_boundaries;
    int gcnt; bit ok;
    logic [W-1:0] gp = '0;
    gp[W-1] = 1'b1;
    run_window(gp, 1'b1, gcnt, ok);
    checks++; if (Result !== 4'd1 || Overflow !== 1'b0) begin
      errors++; $display("FAIL bound_result: got %0d/%b expected 1/0", Result, Overflow); end
    do_ack(3, 1'b1);
    checks++; if (Result !== 4'd1 || Result_valid !== 1'b0) begin
      errors++; $display("FAIL bound_hold_pulses: got %0d/%b expected 1/0", Result, Result_valid); end
  endtask

  task automatic test_random;
    int gcnt; bit ok;
    logic [W-1:0] gp;
    for (int it = 0; it < 6; it++) begin
      gp = (it == 2) ? '1 : W'($urandom);
      run_window(gp, 1'($urandom), gcnt, ok);
      checks++; if (Result !== CW'(exp_count(gp)) || Overflow !== exp_ovf(gp) || !ok || gcnt != W) begin
        errors++; $display("FAIL random_%0d: got %0d/%b expected %0d/%b", it, Result, Overflow, exp_count(gp), exp_ovf(gp)); end
      do_ack($urandom_range(4, 0), 1'($urandom));
    end
  endtask

  task automatic test_idle_rules;
    logic [CW-1:0] prev = Result;
    Start = 1'b1; Stop = 1'b1; tick;
    Start = 1'b0; Stop = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle: got busy=%b expected 0", Busy); end
    Result_ack = 1'b1; tick; Result_ack = 1'b0;
    checks++; if (Result !== prev || Result_valid !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL idle_ack: got %0d/%b expected %0d/0", Result, Result_valid, prev); end
  endtask

  task automatic test_abort;
    int gcnt; bit ok;
    logic [W-1:0] gp = 16'h1111 | 16'h0002;
    run_window(gp, 1'b0, gcnt, ok);
    do_ack(0, 1'b0);
    Start = 1'b1; tick; Start = 1'b0; tick;
    for (int i = 0; i < 7; i++) begin Pulse_ev = 1'b1; tick; end
    Stop = 1'b1; Pulse_ev = 1'b1; tick;
    Stop = 1'b0; Pulse_ev = 1'b0;
    checks++; if (Busy !== 1'b0 || Gate_active !== 1'b0 || Result !== 4'd5 || Result_valid !== 1'b0) begin
      errors++; $display("FAIL abort: got busy=%b gate=%b r=%0d v=%b expected 0 0 5 0", Busy, Gate_active, Result, Result_valid); end
    repeat (W + 4) tick;
    checks++; if (Result_valid !== 1'b0 || Result !== 4'd5) begin
      errors++; $display("FAIL abort_no_latch: got %0d/%b expected 5/0", Result, Result_valid); end
    gp = 16'h0410;
    run_window(gp, 1'b0, gcnt, ok);
    checks++; if (Result !== 4'd2) begin errors++; $display("FAIL after_abort: got %0d expected 2", Result); end
    do_ack(0, 1'b0);
  endtask

  task automatic test_auto_restart;
    logic [W-1:0] gp1 = W'($urandom);
    logic [W-1:0] gp2 = '0;
    int gcnt = 0;
    while ($countones(gp2) < 7) gp2[$urandom_range(W-1, 0)] = 1'b1;
    start_a = 1'b1; tick; start_a = 1'b0; tick;
    for (int i = 0; i < W; i++) begin ev_a = gp1[i]; tick; end
    ev_a = 1'b0;
    checks++; if (vld_a !== 1'b1 || res_a !== CW'(exp_count(gp1)) || ovf_a !== exp_ovf(gp1)) begin
      errors++; $display("FAIL ar_first: got %0d/%b/%b expected %0d/%b/1", res_a, ovf_a, vld_a, exp_count(gp1), exp_ovf(gp1)); end
    repeat (3) tick;
    ack_a = 1'b1; tick; ack_a = 1'b0;
    checks++; if (vld_a !== 1'b0 || busy_a !== 1'b1 || gate_a !== 1'b0) begin
      errors++; $display("FAIL ar_ack: got v=%b busy=%b gate=%b expected 0 1 0", vld_a, busy_a, gate_a); end
    tick;
    for (int i = 0; i < W; i++) begin
      if (gate_a) gcnt++;
      ev_a = gp2[i]; tick;
    end
    ev_a = 1'b0;
    checks++; if (gcnt != W || gate_a !== 1'b0) begin errors++; $display("FAIL ar_gate_len: got %0d expected %0d", gcnt, W); end
    checks++; if (vld_a !== 1'b1 || res_a !== 4'd7 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL ar_second: got %0d/%b/%b expected 7/0/1", res_a, ovf_a, vld_a); end
    stop_a = 1'b1; ack_a = 1'b1; tick; stop_a = 1'b0; ack_a = 1'b0;
    tick;
    checks++; if (busy_a !== 1'b0 || vld_a !== 1'b0 || gate_a !== 1'b0 || res_a !== 4'd7) begin
      errors++; $display("FAIL ar_stop_hold: got busy=%b v=%b gate=%b r=%0d expected 0 0 0 7", busy_a, vld_a, gate_a, res_a); end
  endtask

  task automatic test_reset_mid;
    int gcnt; bit ok; int bad = 0;
    logic [W-1:0] gp = 16'h8421;
    Start = 1'b1; tick; Start = 1'b0; tick;
    for (int i = 0; i < 4; i++) begin
      Pulse_ev = (i < 3);
      if (i == 3) Reset = 1'b0;
      tick;
    end
    Pulse_ev = 1'b0;
    checks++; if ({Result, Result_valid, Overflow, Gate_active, Busy} !== '0) begin
      errors++; $display("FAIL reset_mid: got %h expected 0", {Result, Result_valid, Overflow, Gate_active, Busy}); end
    Reset = 1'b1;
    repeat (W + 4) begin tick; if (Result_valid !== 1'b0 || Busy !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d bad cycles expected 0", bad); end
    run_window(gp, 1'b1, gcnt, ok);
    checks++; if (Result !== 4'd4 || Overflow !== 1'b0 || !ok) begin
      errors++; $display("FAIL reset_mid_next: got %0d/%b expected 4/0", Result, Overflow); end
    do_ack(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_boundaries();
    test_random();
    test_idle_rules();
    test_abort();
    test_auto_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_window_ctrl.md
# pulse_window_ctrl

Measurement-window controller for the pulse counter. Takes the single-cycle pulse events from the 4-sample rising-pulse detector and opens a gate for a fixed number of clock cycles. Inside the gate it counts events with saturation, then latches the total into a result register held under a valid/ack handshake for the display or readout logic. It sequences clear, gate and latch so the downstream counter and display never see a partial count.

## Interface
- WINDOW_CYCLES, 1000, gate length in CLK cycles; must be >= 2.
- CNT_W, 8, width of the event count and result.
- AUTO_RESTART, 0, 1 = start a new window automatically after ack; 0 = return to IDLE.

- CLK  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  level, sampled only in IDLE; begins a measurement.
- Stop  in  1  level; aborts an open gate.
- Pulse_ev  in  1  one-cycle event strobe from the pulse detector.
- Result_ack  in  1  consumer accepts Result.
- Result  out  CNT_W  latched event count.
- Result_valid  out  1  Result holds an unconsumed measurement.
- Overflow  out  1  latched with Result; the count saturated during that window.
- Gate_active  out  1  high while events are being counted.
- Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, GATE, HOLD.
- IDLE:
  - Start=1 and Stop=0 -> CLEAR.
  - Start and Stop both high: Stop wins; stay in IDLE.
- CLEAR: one cycle.
  - count <= 0, ovf <= 0, timer <= WINDOW_CYCLES-1.
  - Always -> GATE.
- GATE: Gate_active=1.
  - Each Pulse_ev increments count.
  - At 2^CNT_W-1 the count holds and ovf sets (sticky).
  - timer decrements each cycle.
  - Stop=1: -> IDLE; Result, Result_valid and Overflow are unchanged; the partial count is discarded.
  - timer==0 and Stop=0: load the result registers, then -> HOLD.
    - Result <= sat(count + Pulse_ev).
    - Overflow <= ovf or that increment saturating.
    - Result_valid <= 1.
    - A pulse on the final gate cycle is counted.
- HOLD: Result_valid=1 until Result_ack is sampled high.
  - On ack: Result_valid <= 0, then -> CLEAR if AUTO_RESTART=1, else -> IDLE.
  - Result and Overflow keep their value after ack until the next latch.
  - Stop in HOLD: completes the handshake, then forces IDLE regardless of AUTO_RESTART.
- Pulse_ev is ignored outside GATE.
- Start is ignored outside IDLE.
- Result_ack is ignored while Result_valid=0.
- Width rules:
  - timer is $clog2(WINDOW_CYCLES) bits.
  - count is CNT_W bits; it never wraps.

## Timing
- Reset (Reset=0 at an edge):
  - Next cycle: state=IDLE, Result=0, Result_valid=0, Overflow=0, Gate_active=0, Busy=0; internal count, ovf and timer all 0.
  - Reset mid-operation aborts immediately, with no result.
- Start sampled at edge k:
  - CLEAR in cycle k+1.
  - Gate_active high in cycles k+2 .. k+1+WINDOW_CYCLES, exactly WINDOW_CYCLES cycles.
  - Result_valid high from edge k+2+WINDOW_CYCLES.
- Ack sampled at edge m: Result_valid low after edge m.
  - With AUTO_RESTART=1, CLEAR is in cycle m+1.
  - With AUTO_RESTART=1, the next gate opens in cycle m+2.
- Stop sampled in GATE at edge j: Gate_active=0 and state=IDLE after edge j.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package pulse_ctrl_pkg:
  - State encoding localparams (IDLE=2'd0, CLEAR=2'd1, GATE=2'd2, HOLD=2'd3).
  - A saturating-increment function, parameterised by width.
- Sub-module gate_timer:
  - Down-counter with load and enable inputs.
  - done output = (value==0).
  - Parameter WINDOW_CYCLES.
- Top level holds the FSM, the event counter and the result registers.

## Test plan
Bench parameters: WINDOW_CYCLES=16, CNT_W=4, 10 ns clock.

1. Basic window:
   - Stimulus: release Reset, Start at edge 0, 5 spaced Pulse_ev inside the gate.
   - Response: Gate_active for 16 cycles; Result_valid=1 at edge 18 with Result=5, Overflow=0.
2. Saturation:
   - Stimulus: Pulse_ev high every gate cycle (16 events).
   - Response: Result=15, Overflow=1.
3. Boundaries:
   - Stimulus: pulses in IDLE, in CLEAR, on the last gate cycle, and in HOLD.
   - Response: only the last-gate-cycle pulse is counted; Result=1.
4. Abort:
   - Stimulus: Stop at gate cycle 8 after a prior Result=5.
   - Response: IDLE next cycle; Result stays 5; Result_valid stays 0.
5. Handshake and auto-restart:
   - Stimulus: AUTO_RESTART=1; ack 3 cycles after valid.
   - Response: Result_valid drops next cycle; new gate opens 2 cycles after ack; second window counts 7 independently.
6. Reset mid-gate:
   - Stimulus: Reset=0 at gate cycle 4 with count=3.
   - Response: all outputs 0 and state IDLE after that edge; no Result_valid.
